// File: rtl/pwm_square_gen_if.sv
// Configuration and sample bus of the square/pulse generator.
interface pwm_square_gen_if #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic                    en;
  logic                    sync;
  logic        [CNT_W-1:0] period;
  logic        [CNT_W-1:0] duty;
  logic signed [OUT_W-1:0] amplitude;
  logic                    unipolar;
  logic                    invert;
  logic signed [OUT_W-1:0] wave_out;
  logic                    phase_out;
  logic                    cycle_start;

  // Controller side: drives configuration, consumes samples
  modport master (
    output en, sync, period, duty, amplitude, unipolar, invert,
    input  wave_out, phase_out, cycle_start
  );

  // Generator side
  modport slave (
    input  en, sync, period, duty, amplitude, unipolar, invert,
    output wave_out, phase_out, cycle_start
  );
endinterface

// File: rtl/pwm_square_gen.sv
// Square/pulse generator with runtime period, duty, amplitude and mode.
// Configuration is captured into shadow registers at cycle boundaries so
// that an update never produces a partial period.
module pwm_square_gen #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_square_gen_if.slave    bus
);

  localparam int unsigned NEG_W = OUT_W + 1;
  localparam logic signed [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [CNT_W-1:0] per_q, per_d;
  logic        [CNT_W-1:0] duty_q, duty_d;
  logic signed [OUT_W-1:0] amp_q, amp_d;
  logic                    uni_q, uni_d;
  logic                    inv_q, inv_d;
  logic signed [OUT_W-1:0] wave_q, wave_d;
  logic                    phase_q, phase_d;
  logic                    cs_q, cs_d;

  logic signed [NEG_W-1:0] amp_ext_c;
  logic signed [NEG_W-1:0] amp_neg_c;
  logic signed [OUT_W-1:0] low_bip_c;
  logic                    hi_c;
  logic signed [OUT_W-1:0] level_c;

  // Phase and level of the current counter position from shadow state
  always_comb begin
    amp_ext_c = {amp_q[OUT_W-1], amp_q};
    amp_neg_c = -amp_ext_c;
    low_bip_c = (amp_q == MIN_NEG) ? MAX_POS : amp_neg_c[OUT_W-1:0];
    hi_c      = (cnt_q < duty_q) ^ inv_q;
    if (hi_c) begin
      level_c = amp_q;
    end else if (uni_q) begin
      level_c = '0;
    end else begin
      level_c = low_bip_c;
    end
  end

  // Next-state, shadow load and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    duty_d  = duty_q;
    amp_d   = amp_q;
    uni_d   = uni_q;
    inv_d   = inv_q;
    wave_d  = '0;
    phase_d = 1'b0;
    cs_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = ST_RUN;
          per_d   = bus.period;
          duty_d  = bus.duty;
          amp_d   = bus.amplitude;
          uni_d   = bus.unipolar;
          inv_d   = bus.invert;
        end
      end
      ST_RUN: begin
        wave_d  = level_c;
        phase_d = hi_c;
        cs_d    = (cnt_q == '0);
        if (!bus.en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if ((cnt_q == per_q) || bus.sync) begin
          // Wrap and sync share one load, so a coincident sync adds no strobe
          cnt_d  = '0;
          per_d  = bus.period;
          duty_d = bus.duty;
          amp_d  = bus.amplitude;
          uni_d  = bus.unipolar;
          inv_d  = bus.invert;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      amp_q   <= '0;
      uni_q   <= 1'b0;
      inv_q   <= 1'b0;
      wave_q  <= '0;
      phase_q <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      amp_q   <= amp_d;
      uni_q   <= uni_d;
      inv_q   <= inv_d;
      wave_q  <= wave_d;
      phase_q <= phase_d;
      cs_q    <= cs_d;
    end
  end

  assign bus.wave_out    = wave_q;
  assign bus.phase_out   = phase_q;
  assign bus.cycle_start = cs_q;

endmodule

// File: tb/tb_pwm_square_gen.sv
// Bench for pwm_square_gen: directed scenarios plus randomized traffic,
// all checked against a per-sample model of the waveform rules.
module tb_pwm_square_gen;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pwm_square_gen_if #(.OUT_W(8), .CNT_W(16)) bus ();

  pwm_square_gen #(.OUT_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position in period, captured config, expected sample
  bit       m_run;
  int       m_pos;
  int       m_p, m_d, m_a;
  bit       m_uni, m_inv;
  logic [9:0] exp_v;

  function automatic logic [9:0] obs();
    return {bus.wave_out, bus.phase_out, bus.cycle_start};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_p = 0; m_d = 0; m_a = 0; m_uni = 0; m_inv = 0;
    exp_v = '0;
  endtask

  // Expected sample from pre-edge position, then advance position
  task automatic model_step();
    bit hi;
    int lvl;
    logic [7:0] w;
    if (m_run) begin
      hi = (m_pos < m_d) != m_inv;
      if (hi)        lvl = m_a;
      else if (m_uni) lvl = 0;
      else           lvl = (-m_a > 127) ? 127 : -m_a;
      w = 8'(lvl);
      exp_v = {w, hi, (m_pos == 0)};
    end else begin
      exp_v = '0;
    end
    if (!bus.en) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run || m_pos == m_p || bus.sync) begin
      m_p = int'(bus.period); m_d = int'(bus.duty);
      m_a = int'($signed(bus.amplitude));
      m_uni = bus.unipolar; m_inv = bus.invert;
      m_pos = 0; m_run = 1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg(input int p, input int d, input int a, input bit u, input bit v);
    bus.period = 16'(p); bus.duty = 16'(d); bus.amplitude = 8'(a);
    bus.unipolar = u; bus.invert = v;
  endtask

  // Advance until the model sits at the given position (bounded)
  task automatic wait_pos(input int target, input string name);
    int k;
    k = 0;
    while (m_pos != target && k < 40) begin tick(); k++; end
    if (m_pos != target) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout waiting for position %0d", name, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 0; bus.sync = 0; cfg(9, 5, 20, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== 10'h0) begin n_fail++; $display("FAIL reset_hold got %h want 000", obs()); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sync = 1'($urandom); cfg($urandom_range(0, 20), $urandom_range(0, 20), $urandom, 1'($urandom), 1'($urandom));
      tick();
      n_tests++;
      if (obs() !== 10'h0 || obs() !== exp_v) begin n_fail++; $display("FAIL reset_idle got %h want 000", obs()); end
    end
    bus.sync = 0;
  endtask

  task automatic test_basic();
    int ncs;
    cfg(9, 5, 20, 0, 0);
    bus.en = 1;
    tick();
    n_tests++;
    if (obs() !== 10'h0) begin n_fail++; $display("FAIL basic_latency1 got %h want 000", obs()); end
    tick();
    n_tests++;
    if (bus.wave_out !== 8'sd20 || bus.cycle_start !== 1'b1) begin
      n_fail++; $display("FAIL basic_first_sample got wave=%0d cs=%b want 20/1", bus.wave_out, bus.cycle_start);
    end
    ncs = 1;
    for (int i = 1; i < 30; i++) begin
      tick();
      if (bus.cycle_start) ncs++;
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL basic i=%0d got %h want %h", i, obs(), exp_v); end
      n_tests++;
      if (bus.wave_out !== ((i % 10) < 5 ? 8'sd20 : -8'sd20)) begin
        n_fail++; $display("FAIL basic_level i=%0d got %0d", i, bus.wave_out);
      end
    end
    n_tests++;
    if (ncs != 3) begin n_fail++; $display("FAIL basic_cs_count got %0d want 3", ncs); end
  endtask

  task automatic test_midchange();
    int k;
    wait_pos(3, "midchange");
    cfg(3, 1, 50, 0, 0);
    // Finish the old period: samples for positions 3..9
    for (int i = 3; i <= 9; i++) begin
      tick();
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL midchange_old got %h want %h", obs(), exp_v); end
    end
    k = 0;
    do begin tick(); k++; end while (!bus.cycle_start && k < 12);
    n_tests++;
    if (bus.wave_out !== 8'sd50) begin n_fail++; $display("FAIL midchange_new0 got %0d want 50", bus.wave_out); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== -8'sd50 || bus.cycle_start !== 1'b0) begin
        n_fail++; $display("FAIL midchange_new%0d got %0d/%b want -50/0", i, bus.wave_out, bus.cycle_start);
      end
    end
    tick();
    n_tests++;
    if (bus.cycle_start !== 1'b1) begin n_fail++; $display("FAIL midchange_period got cs=%b want 1", bus.cycle_start); end
  endtask

  task automatic test_min_amp();
    logic [7:0] want [4];
    bus.en = 0; tick(); tick();
    cfg(3, 2, -128, 0, 0);
    bus.en = 1; tick();
    want = '{8'h80, 8'h80, 8'h7F, 8'h7F};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== want[i]) begin n_fail++; $display("FAIL minamp_bip%0d got %h want %h", i, bus.wave_out, want[i]); end
    end
    cfg(3, 2, -128, 1, 0);
    repeat (4) tick();
    want = '{8'h80, 8'h80, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== want[i] || obs() !== exp_v) begin
        n_fail++; $display("FAIL minamp_uni%0d got %h want %h", i, bus.wave_out, want[i]);
      end
    end
    cfg(3, 2, -128, 1, 1);
    repeat (4) tick();
    want = '{8'h00, 8'h00, 8'h80, 8'h80};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== want[i] || obs() !== exp_v) begin
        n_fail++; $display("FAIL minamp_inv%0d got %h want %h", i, bus.wave_out, want[i]);
      end
    end
  endtask

  task automatic test_sync();
    int ncs;
    cfg(7, 3, 40, 0, 0);
    wait_pos(4, "sync_mid");
    wait_pos(4, "sync_mid2");
    bus.sync = 1; tick(); bus.sync = 0;
    tick();
    n_tests++;
    if (bus.cycle_start !== 1'b1 || obs() !== exp_v) begin
      n_fail++; $display("FAIL sync_restart got %h want %h", obs(), exp_v);
    end
    wait_pos(7, "sync_wrap");
    bus.sync = 1; tick(); bus.sync = 0;
    ncs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.cycle_start) ncs++;
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL sync_wrap i=%0d got %h want %h", i, obs(), exp_v); end
    end
    n_tests++;
    if (ncs != 2) begin n_fail++; $display("FAIL sync_wrap_count got %0d want 2", ncs); end
    bus.en = 0; bus.sync = 1; tick(); tick();
    n_tests++;
    if (obs() !== 10'h0) begin n_fail++; $display("FAIL sync_en_low got %h want 000", obs()); end
    bus.sync = 0;
  endtask

  task automatic test_duty_edges();
    bus.en = 1;
    cfg(9, 0, 30, 0, 0);
    repeat (14) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== -8'sd30 || bus.phase_out !== 1'b0) begin
        n_fail++; $display("FAIL duty_zero got %0d/%b want -30/0", bus.wave_out, bus.phase_out);
      end
    end
    cfg(9, 12, 30, 0, 0);
    repeat (12) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (bus.wave_out !== 8'sd30 || obs() !== exp_v) begin
        n_fail++; $display("FAIL duty_over got %0d want 30", bus.wave_out);
      end
    end
  endtask

  task automatic test_enable_drop();
    cfg(9, 5, 25, 0, 0);
    wait_pos(6, "endrop");
    bus.en = 0;
    tick();
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL endrop_last got %h want %h", obs(), exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs() !== 10'h0) begin n_fail++; $display("FAIL endrop_zero got %h want 000", obs()); end
    end
    bus.en = 1;
    tick();
    tick();
    n_tests++;
    if (bus.cycle_start !== 1'b1 || bus.wave_out !== 8'sd25) begin
      n_fail++; $display("FAIL endrop_restart got %0d/%b want 25/1", bus.wave_out, bus.cycle_start);
    end
  endtask

  task automatic test_async_reset();
    cfg(5, 2, 60, 0, 0);
    bus.en = 1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 10'h0) begin n_fail++; $display("FAIL async_reset got %h want 000", obs()); end
    model_reset();
    bus.en = 0;
    #1 rst_n = 1'b1;
    tick();
    bus.en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL async_restart i=%0d got %h want %h", i, obs(), exp_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.en   = ($urandom_range(0, 15) != 0);
      bus.sync = ($urandom_range(0, 11) == 0);
      cfg($urandom_range(0, 12), $urandom_range(0, 15), $urandom, 1'($urandom), 1'($urandom));
      tick();
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL random i=%0d got %h want %h", i, obs(), exp_v); end
    end
    bus.sync = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_midchange();
    test_min_amp();
    test_sync();
    test_duty_edges();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
